x_skew_feeder: RTL and testbench

- Feeds the systolic array's X input: captures a full M×N activation matrix on a start pulse.
- Streams it row by row, diagonally skewed, so lane j is delayed j cycles relative to lane 0.
- Replaces the free-running per-lane delay pipes in front of the array with one controlled, restartable source.
- Provides busy/done status to the surrounding controller; the array's X port connects directly to X_out.

---
 rtl/x_skew_feeder_pkg.sv | 25 ++
 rtl/x_skew_lane_sel.sv | 36 +++
 rtl/x_skew_feeder.sv | 128 ++++++++++++
 tb/tb_x_skew_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x_skew_feeder_pkg
// Description : Shared defaults, FSM encoding and step-counter sizing for the
//               systolic-array X skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package x_skew_feeder_pkg;

    localparam int c_DEF_M          = 5;
    localparam int c_DEF_N          = 3;
    localparam int c_DEF_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Counter must reach M+N-1 (the end-of-stream marker), so size for M+N.
    function automatic int step_cnt_width(input int m, input int n);
        return $clog2(m + n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_skew_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : x_skew_lane_sel
// Description : Per-lane selector: picks element X[step-LANE][LANE] from the
//               flat matrix, or a zero bubble when outside the matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module x_skew_lane_sel
    import x_skew_feeder_pkg::*;
#(
    parameter int M          = c_DEF_M,
    parameter int N          = c_DEF_N,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int CNT_W      = step_cnt_width(M, N),
    parameter int LANE       = 0
) (
    input  logic [DATA_WIDTH*M*N-1:0] mat,
    input  logic [CNT_W-1:0]          step,
    output logic [DATA_WIDTH-1:0]     elem,
    output logic                      valid
);

    // Row r reaches this lane exactly at step r+LANE; unrolled into a mux.
    always_comb begin
        elem  = '0;
        valid = 1'b0;
        for (int r = 0; r < M; r++) begin
            if (32'(step) == r + LANE) begin
                elem  = mat[(r*N + LANE)*DATA_WIDTH +: DATA_WIDTH];
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : x_skew_feeder
// Description : Captures an MxN activation matrix on start and streams it
//               diagonally skewed into the systolic array X port.
// Revision    : 1.0 - initial release
// ============================================================================
module x_skew_feeder
    import x_skew_feeder_pkg::*;
#(
    parameter int M          = c_DEF_M,
    parameter int N          = c_DEF_N,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH*M*N-1:0] X_mat,
    output logic [DATA_WIDTH*N-1:0]   X_out,
    output logic [N-1:0]              lane_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int               c_CNT_W = step_cnt_width(M, N);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(M + N - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_step;
    logic [c_CNT_W-1:0]        w_step_nxt;
    logic [DATA_WIDTH*M*N-1:0] r_mat;
    logic [DATA_WIDTH*N-1:0]   r_x_out;
    logic [DATA_WIDTH*N-1:0]   w_x_out_nxt;
    logic [N-1:0]              r_valid;
    logic [N-1:0]              w_valid_nxt;
    logic                      r_done;
    logic                      w_done_nxt;
    logic                      w_accept;
    logic [DATA_WIDTH*M*N-1:0] w_sel_mat;
    logic [c_CNT_W-1:0]        w_sel_step;
    logic [DATA_WIDTH*N-1:0]   w_lane_data;
    logic [N-1:0]              w_lane_valid;

    assign w_accept = start && (r_state == ST_IDLE);

    // On acceptance step 0 must come straight from X_mat, not the stale capture.
    assign w_sel_mat  = w_accept ? X_mat : r_mat;
    assign w_sel_step = w_accept ? '0 : r_step;

    for (genvar j = 0; j < N; j++) begin : g_lane
        x_skew_lane_sel #(
            .M          (M),
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_W      (c_CNT_W),
            .LANE       (j)
        ) u_sel (
            .mat   (w_sel_mat),
            .step  (w_sel_step),
            .elem  (w_lane_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .valid (w_lane_valid[j])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_x_out_nxt = '0;
        w_valid_nxt = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_STREAM;
                    w_step_nxt  = c_CNT_W'(1);
                    w_x_out_nxt = w_lane_data;
                    w_valid_nxt = w_lane_valid;
                end
            end
            ST_STREAM: begin
                if (r_step == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_step_nxt  = r_step + 1'b1;
                    w_x_out_nxt = w_lane_data;
                    w_valid_nxt = w_lane_valid;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_x_out <= '0;
            r_valid <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_x_out <= w_x_out_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Captured matrix is don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mat <= X_mat;
        end
    end

    assign X_out      = r_x_out;
    assign lane_valid = r_valid;
    assign busy       = (r_state == ST_STREAM);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_x_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_skew_feeder
// Description : Self-checking bench: fixed vector table, corner sequences and
//               randomized traffic against a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_skew_feeder;

    localparam int M  = 5;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int L  = M + N - 1;
    localparam int M2 = 4;
    localparam int N2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start;
    logic [DW*M*N-1:0]   X_mat;
    logic [DW*N-1:0]     X_out;
    logic [N-1:0]        lane_valid;
    logic                busy;
    logic                done;

    logic                rst2;
    logic                start2;
    logic [DW*M2*N2-1:0] X_mat2;
    logic [DW*N2-1:0]    X_out2;
    logic [N2-1:0]       lane_valid2;
    logic                busy2;
    logic                done2;

    x_skew_feeder #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .X_mat      (X_mat),
        .X_out      (X_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    x_skew_feeder #(.M(M2), .N(N2), .DATA_WIDTH(DW)) dut_deg (
        .clk        (clk),
        .rst        (rst2),
        .start      (start2),
        .X_mat      (X_mat2),
        .X_out      (X_out2),
        .lane_valid (lane_valid2),
        .busy       (busy2),
        .done       (done2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remembers the accepted matrix and how many edges have
    // elapsed since acceptance; lane j shows row (elapsed - j) when in range.
    logic [DW-1:0]   m_mat [M][N];
    bit              m_busy = 1'b0;
    int              m_s    = 0;
    logic [DW*N-1:0] e_out;
    logic [N-1:0]    e_val;
    bit              e_done;

    typedef struct {
        bit          rst;
        bit          start;
        bit          alt;
        logic [23:0] out;
        logic [2:0]  val;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t tbl [10];

    logic [DW*M*N-1:0] base_mat;
    logic [DW*M*N-1:0] alt_mat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW*M*N-1:0] rand_mat();
        logic [DW*M*N-1:0] v;
        for (int i = 0; i < M*N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit st, input logic [DW*M*N-1:0] mat);
        e_done = 1'b0;
        if (r) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (st) begin
                for (int rr = 0; rr < M; rr++)
                    for (int j = 0; j < N; j++)
                        m_mat[rr][j] = mat[(rr*N + j)*DW +: DW];
                m_busy = 1'b1;
                m_s    = 0;
            end
        end else begin
            m_s++;
            if (m_s == L) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end
        end
        e_out = '0;
        e_val = '0;
        if (m_busy) begin
            for (int j = 0; j < N; j++) begin
                if (m_s - j >= 0 && m_s - j < M) begin
                    e_out[j*DW +: DW] = m_mat[m_s - j][j];
                    e_val[j]          = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit st, input logic [DW*M*N-1:0] mat);
        rst   = r;
        start = st;
        X_mat = mat;
        @(posedge clk);
        model_edge(r, st, mat);
        #1;
        check("x_out", 32'(X_out), 32'(e_out));
        check("lane_valid", 32'(lane_valid), 32'(e_val));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(e_done));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_done;
        int n_v2;
        logic [7:0] exp2 [4];

        rst    = 1'b1;
        start  = 1'b0;
        X_mat  = '0;
        rst2   = 1'b1;
        start2 = 1'b0;
        X_mat2 = '0;

        for (int r = 0; r < M; r++)
            for (int j = 0; j < N; j++)
                base_mat[(r*N + j)*DW +: DW] = DW'(16*r + j + 1);
        alt_mat = ~base_mat;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 24'h000000, 3'b000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 24'h000001, 3'b001, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 24'h000211, 3'b011, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 24'h031221, 3'b111, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 24'h132231, 3'b111, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 24'h233241, 3'b111, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 24'h334200, 3'b110, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 24'h430000, 3'b100, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 24'h000000, 3'b000, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 24'h000000, 3'b000, 1'b0, 1'b0};

        // Basic stream with an ignored start and X_mat churn mid-stream
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].rst, tbl[i].start, tbl[i].alt ? alt_mat : base_mat);
            check("tbl_x_out", 32'(X_out), 32'(tbl[i].out));
            check("tbl_lane_valid", 32'(lane_valid), 32'(tbl[i].val));
            check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
            check("tbl_done", 32'(done), 32'(tbl[i].done));
        end

        // Back-to-back: start held high
        n_done = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 1'b1, base_mat);
            if (done) n_done++;
        end
        check("b2b_done_count", 32'(n_done), 32'd2);
        for (int i = 0; i < L + 2; i++) cycle(1'b0, 1'b0, base_mat);

        // Reset mid-stream: abort, no done, clean restart
        cycle(1'b0, 1'b1, rand_mat());
        cycle(1'b0, 1'b0, base_mat);
        cycle(1'b0, 1'b0, base_mat);
        cycle(1'b1, 1'b0, base_mat);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_x_out", 32'(X_out), 32'd0);
        n_done = 0;
        for (int i = 0; i < L + 2; i++) begin
            cycle(1'b0, 1'b0, base_mat);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        cycle(1'b0, 1'b1, base_mat);
        check("restart_step0", 32'(X_out), 32'h000001);
        for (int i = 0; i < L + 1; i++) cycle(1'b0, 1'b0, base_mat);

        // Reset and start together: reset wins
        cycle(1'b1, 1'b1, base_mat);
        check("collide_busy", 32'(busy), 32'd0);
        check("collide_x_out", 32'(X_out), 32'd0);
        cycle(1'b0, 1'b1, base_mat);
        check("collide_next_step0", 32'(X_out), 32'h000001);
        check("collide_next_valid", 32'(lane_valid), 32'b001);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, rand_mat());
        end

        // Degenerate N=1, M=4 instance
        exp2[0] = 8'h01;
        exp2[1] = 8'h11;
        exp2[2] = 8'h21;
        exp2[3] = 8'h31;
        @(negedge clk);
        rst2   = 1'b0;
        X_mat2 = {8'h31, 8'h21, 8'h11, 8'h01};
        start2 = 1'b1;
        n_v2   = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            start2 = 1'b0;
            X_mat2 = '0;
            if (lane_valid2 == 1'b1) n_v2++;
            if (e < 4) begin
                check("deg_x_out", 32'(X_out2), 32'(exp2[e]));
                check("deg_busy", 32'(busy2), 32'd1);
            end else if (e == 4) begin
                check("deg_done", 32'(done2), 32'd1);
                check("deg_x_out_end", 32'(X_out2), 32'd0);
            end else begin
                check("deg_done_clear", 32'(done2), 32'd0);
            end
        end
        check("deg_valid_cycles", 32'(n_v2), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
